// File: rtl/ram_8_pkg.sv
// ram_8_pkg: shared widths, FSM state encoding and word type for the RAM burst controller
package ram_8_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR_BITS = 3;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} burst_state_t;
  typedef logic [DEF_WIDTH-1:0] ram_word_t;
endpackage

// File: rtl/burst_addr_counter.sv
// burst_addr_counter: current burst address (wrapping mod depth) and words-left tracking
module burst_addr_counter #(
  parameter int ADDR_BITS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [ADDR_BITS-1:0] i_len,
  input  logic                 i_step,
  output logic [ADDR_BITS-1:0] o_cur_addr,
  output logic                 o_last
);
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_rem;
  // load base/len on command accept, advance one word per beat; address wraps naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_BITS'(1);
      r_rem  <= (r_rem == '0) ? r_rem : r_rem - ADDR_BITS'(1);
    end
  end
  assign o_cur_addr = r_addr;
  assign o_last = (r_rem == '0);
endmodule

// File: rtl/my_ram_8.sv
// my_ram_8: 8-word RAM with synchronous write and combinational read
module my_ram_8 #(
  parameter int WIDTH = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 i_clk,
  input  logic [WIDTH-1:0]     i_in,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 i_load,
  output logic [WIDTH-1:0]     o_out
);
  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];
  // capture the input word at the addressed location when load is high
  always_ff @(posedge i_clk) begin
    if (i_load) r_mem[i_addr] <= i_in;
  end
  assign o_out = r_mem[i_addr];
endmodule

// File: rtl/ram_8_burst_ctrl.sv
// ram_8_burst_ctrl: moves 1-8 word bursts between valid/ready streams and the my_ram_8 port
module ram_8_burst_ctrl
  import ram_8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_write,
  input  logic [ADDR_BITS-1:0] i_cmd_base,
  input  logic [ADDR_BITS-1:0] i_cmd_len,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [WIDTH-1:0]     i_wr_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [WIDTH-1:0]     o_rd_data,
  output logic                 o_done,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [WIDTH-1:0]     o_mem_in,
  output logic                 o_mem_load,
  input  logic [WIDTH-1:0]     i_mem_out
);
  burst_state_t r_state;
  logic w_idle, w_wr, w_rd, w_load, w_step, w_last;
  assign w_idle = (r_state == S_IDLE);
  assign w_wr   = (r_state == S_WRITE);
  assign w_rd   = (r_state == S_READ);
  assign w_load = w_idle && i_cmd_valid;
  assign w_step = (w_wr && i_wr_valid) || (w_rd && i_rd_ready);

  burst_addr_counter #(.ADDR_BITS(ADDR_BITS)) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_base     (i_cmd_base),
    .i_len      (i_cmd_len),
    .i_step     (w_step),
    .o_cur_addr (o_mem_addr),
    .o_last     (w_last)
  );

  // burst sequencing: accept in IDLE, finish on the beat that consumes the last word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (i_cmd_valid) r_state <= i_cmd_write ? S_WRITE : S_READ;
        S_WRITE: if (i_wr_valid && w_last) r_state <= S_DONE;
        S_READ:  if (i_rd_ready && w_last) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // state decodes; load follows wr_valid directly so a reset drops it at once
  assign o_cmd_ready = w_idle;
  assign o_wr_ready  = w_wr;
  assign o_rd_valid  = w_rd;
  assign o_done      = (r_state == S_DONE);
  assign o_mem_load  = w_wr && i_wr_valid;
  assign o_mem_in    = w_wr ? i_wr_data : '0;
  assign o_rd_data   = i_mem_out;
endmodule

// File: tb/tb_ram_8_burst_ctrl.sv
// tb_ram_8_burst_ctrl: directed and randomized bursts checked against an array model of the RAM
module tb_ram_8_burst_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_write = 0;
  logic [2:0] cmd_base = 0, cmd_len = 0;
  logic wr_valid = 0, rd_ready = 0;
  logic [15:0] wr_data = 0;
  logic cmd_ready, wr_ready, rd_valid, done, mem_load;
  logic [15:0] rd_data, mem_in, mem_out;
  logic [2:0] mem_addr;
  logic [15:0] model [8];
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_8_burst_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_write(cmd_write), .i_cmd_base(cmd_base), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_done(done),
    .o_mem_addr(mem_addr), .o_mem_in(mem_in), .o_mem_load(mem_load), .i_mem_out(mem_out)
  );

  my_ram_8 u_ram (.i_clk(clk), .i_in(mem_in), .i_addr(mem_addr), .i_load(mem_load), .o_out(mem_out));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input logic [2:0] addr);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_mem_load"}, mem_load, 0);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_mem_in"}, mem_in, 0);
  endtask

  task automatic accept(input bit wr, input int base, input int len);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_base = 3'(base); cmd_len = 3'(len);
    #1 chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
  endtask

  task automatic finish_burst(input string tag, input int acc, input int len, input int stalls, input logic [2:0] end_addr);
    @(negedge clk);
    wr_valid = 0; rd_ready = 0;
    #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_done_load"}, mem_load, 0);
    chk({tag, "_done_mem_in"}, mem_in, 0);
    chk({tag, "_done_rd_valid"}, rd_valid, 0);
    chk({tag, "_latency"}, cyc - acc, len + 1 + stalls);
    @(negedge clk);
    cmd_valid = 0;
    #1 idle_chk({tag, "_post"}, end_addr);
  endtask

  // dstart < 0 means random data; gap = leading wr_valid-low cycles; rnd adds random stalls
  task automatic wr_burst(input string tag, input int base, input int len, input int gap, input bit rnd, input int dstart);
    int k, stalls, acc, t;
    logic [2:0] a;
    logic [15:0] d;
    bit v;
    k = 0; stalls = 0; t = 0;
    accept(1, base, len);
    @(negedge clk);
    acc = cyc;
    while (k <= len && t < 200) begin
      if (t > 0) @(negedge clk);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_base = 3'($urandom); cmd_len = 3'($urandom);
      v = (t >= gap) && (!rnd || $urandom_range(0, 2) != 0);
      a = 3'(base + k);
      d = (dstart < 0) ? 16'($urandom) : 16'(dstart + k);
      wr_valid = v; wr_data = d;
      #1;
      chk({tag, "_wr_ready"}, wr_ready, 1);
      chk({tag, "_mem_load"}, mem_load, v);
      chk({tag, "_mem_addr"}, mem_addr, a);
      chk({tag, "_mem_in"}, mem_in, d);
      chk({tag, "_busy_done"}, done, 0);
      chk({tag, "_busy_cmd_ready"}, cmd_ready, 0);
      if (v) begin model[a] = d; k++; end else stalls++;
      t++;
    end
    chk({tag, "_beats"}, k, len + 1);
    finish_burst(tag, acc, len, stalls, 3'(base + len + 1));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready 1,0,0,1 then steady
  task automatic rd_burst(input string tag, input int base, input int len, input int mode);
    int k, stalls, acc, t;
    logic [2:0] a;
    logic [3:0] pat;
    bit r;
    k = 0; stalls = 0; t = 0; pat = 4'b1001;
    accept(0, base, len);
    @(negedge clk);
    acc = cyc;
    while (k <= len && t < 200) begin
      if (t > 0) @(negedge clk);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_base = 3'($urandom); cmd_len = 3'($urandom);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : (t < 4) ? pat[t] : 1'b1;
      rd_ready = r;
      a = 3'(base + k);
      #1;
      chk({tag, "_rd_valid"}, rd_valid, 1);
      chk({tag, "_mem_addr"}, mem_addr, a);
      chk({tag, "_rd_data"}, rd_data, model[a]);
      chk({tag, "_mem_load"}, mem_load, 0);
      chk({tag, "_wr_ready"}, wr_ready, 0);
      chk({tag, "_busy_done"}, done, 0);
      if (r) k++; else stalls++;
      t++;
    end
    chk({tag, "_beats"}, k, len + 1);
    if (mode == 2) chk({tag, "_stalls"}, stalls, 2);
    finish_burst(tag, acc, len, stalls, 3'(base + len + 1));
  endtask

  initial begin
    #2 idle_chk("reset_async", 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 idle_chk("idle_hold", 0);
    end
    wr_burst("wr_full", 0, 7, 0, 0, 2);
    rd_burst("rd_full", 0, 7, 0);
    wr_burst("wr_wrap", 6, 3, 0, 0, 'hA);
    chk("wrap_model6", model[6], 'hA);
    chk("wrap_model1", model[1], 'hD);
    rd_burst("rd_wrap", 6, 3, 0);
    rd_burst("rd_stall", 2, 3, 2);
    wr_burst("wr_gap", 5, 0, 3, 0, -1);
    rd_burst("rd_gap", 5, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) wr_burst("rnd_wr", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 1, -1);
      else rd_burst("rnd_rd", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
    end
    accept(1, 3, 4);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      wr_valid = 1; wr_data = 16'($urandom);
      model[3'(3 + k)] = wr_data;
      #1 chk("abort_load_pre", mem_load, 1);
    end
    @(negedge clk);
    wr_valid = 1; wr_data = 16'hDEAD;
    rst = 1;
    #1 idle_chk("abort_reset", 0);
    @(negedge clk);
    rst = 0; wr_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 idle_chk("abort_after", 0);
    end
    rd_burst("abort_readback", 3, 4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
